// File: rtl/fft_pkg.sv
// Shared types and constants for the 8-point radix-2 DIT FFT.
// Holds the binary32 container, the complex pair, and the bit-reverse index helper.
package fft_pkg;

  localparam int N     = 8;
  localparam int LOG2N = 3;

  typedef logic [31:0] float32_t;

  localparam float32_t FP_ZERO = 32'h0000_0000;
  localparam float32_t FP_C707 = 32'h3F35_04F3;

  typedef struct packed {
    float32_t re;
    float32_t im;
  } cplx_t;

  function automatic int bitrev(input int i);
    int r;
    r = 0;
    for (int k = 0; k < LOG2N; k++) r[LOG2N-1-k] = i[k];
    return r;
  endfunction

endpackage

// File: rtl/fft_bfly.sv
// One radix-2 butterfly: p = a + W*b, q = a - W*b, with W = exp(-j*2*pi*TW/8).
// W0 and W2 need no arithmetic; W1 and W3 use two constant multiplies plus an add/sub.
module fft_bfly
  import fft_pkg::*;
#(
  parameter int TW = 0
) (
  input  cplx_t a,
  input  cplx_t b,
  output cplx_t p,
  output cplx_t q
);

  float32_t wr, wi, p_re, p_im, q_re, q_im;

  if (TW == 0) begin : g_w0
    assign wr = b.re;
    assign wi = b.im;
  end else if (TW == 2) begin : g_w2
    assign wr = b.im;
    assign wi = {~b.re[31], b.re[30:0]};
  end else begin : g_wc
    float32_t c_re, c_im;
    fp_mul u_mul_re (.a(FP_C707), .b(b.re), .y(c_re));
    fp_mul u_mul_im (.a(FP_C707), .b(b.im), .y(c_im));
    if (TW == 1) begin : g_w1
      // c(1-j)(br + j bi) = (c*br + c*bi) + j(c*bi - c*br)
      fp_addsub u_re (.a(c_re), .b(c_im), .op(1'b0), .y(wr));
      fp_addsub u_im (.a(c_im), .b(c_re), .op(1'b1), .y(wi));
    end else begin : g_w3
      // -c(1+j)(br + j bi) = (c*bi - c*br) + j(-c*br - c*bi)
      fp_addsub u_re (.a(c_im), .b(c_re), .op(1'b1), .y(wr));
      fp_addsub u_im (.a({~c_re[31], c_re[30:0]}), .b(c_im), .op(1'b1), .y(wi));
    end
  end

  fp_addsub u_p_re (.a(a.re), .b(wr), .op(1'b0), .y(p_re));
  fp_addsub u_p_im (.a(a.im), .b(wi), .op(1'b0), .y(p_im));
  fp_addsub u_q_re (.a(a.re), .b(wr), .op(1'b1), .y(q_re));
  fp_addsub u_q_im (.a(a.im), .b(wi), .op(1'b1), .y(q_im));

  assign p = '{re: p_re, im: p_im};
  assign q = '{re: q_re, im: q_im};

endmodule

// File: rtl/fp_addsub.sv
// Combinational binary32 add/subtract (op=1 subtracts b), round-to-nearest-even.
// Subnormal operands and results flush to +0, overflow saturates to infinity, and any zero sum is +0.
module fp_addsub
  import fft_pkg::*;
(
  input  float32_t a,
  input  float32_t b,
  input  logic     op,
  output float32_t y
);

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  logic        sb, a_big, s_big, s_small, eff_sub, round_up;
  logic [7:0]  ea, eb, e_big, e_small, diff;
  logic [22:0] fa, fb, frac;
  logic [23:0] m_big, m_small;
  logic [4:0]  sh, lz;
  logic [55:0] wide;
  logic [26:0] aligned, norm;
  logic [27:0] sum;
  logic [24:0] mr;
  logic [9:0]  exp_n;

  always_comb begin
    ea      = a[30:23];
    eb      = b[30:23];
    fa      = (ea == 8'd0) ? 23'd0 : a[22:0];
    fb      = (eb == 8'd0) ? 23'd0 : b[22:0];
    sb      = b[31] ^ op;
    a_big   = {ea, fa} >= {eb, fb};
    s_big   = a_big ? a[31] : sb;
    s_small = a_big ? sb : a[31];
    e_big   = a_big ? ea : eb;
    e_small = a_big ? eb : ea;
    m_big   = a_big ? {ea != 8'd0, fa} : {eb != 8'd0, fb};
    m_small = a_big ? {eb != 8'd0, fb} : {ea != 8'd0, fa};

    // Align into a 27-bit field: 24 mantissa bits, then guard, round and a sticky bit.
    diff    = e_big - e_small;
    sh      = (diff > 8'd31) ? 5'd31 : diff[4:0];
    wide    = {m_small, 32'd0} >> sh;
    aligned = {wide[55:30], wide[29] | (|wide[28:0])};

    eff_sub = s_big ^ s_small;
    sum     = eff_sub ? ({1'b0, m_big, 3'b000} - {1'b0, aligned})
                      : ({1'b0, m_big, 3'b000} + {1'b0, aligned});

    lz = lzc27(sum[26:0]);
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_n = {2'b00, e_big} + 10'd1;
    end else begin
      norm  = sum[26:0] << lz;
      exp_n = {2'b00, e_big} - {5'd0, lz};
    end

    round_up = norm[2] & (norm[3] | norm[1] | norm[0]);
    mr       = {1'b0, norm[26:3]} + {24'd0, round_up};
    if (mr[24]) begin
      exp_n = exp_n + 10'd1;
      frac  = mr[23:1];
    end else begin
      frac  = mr[22:0];
    end

    if (sum == 28'd0 || exp_n[9] || exp_n == 10'd0) y = FP_ZERO;
    else if (exp_n >= 10'd255)                      y = {s_big, 8'hFF, 23'd0};
    else                                            y = {s_big, exp_n[7:0], frac};
  end

endmodule

// File: rtl/fp_mul.sv
// Combinational binary32 multiply, round-to-nearest-even.
// A zero or subnormal operand gives +0; overflow saturates to infinity.
module fp_mul
  import fft_pkg::*;
(
  input  float32_t a,
  input  float32_t b,
  output float32_t y
);

  logic        sign, hi, guard, sticky, rnd, zero_in;
  logic [23:0] ma, mb, m24;
  logic [47:0] p;
  logic [24:0] mr;
  logic [9:0]  exp_n;
  logic [22:0] frac;

  always_comb begin
    zero_in = (a[30:23] == 8'd0) || (b[30:23] == 8'd0);
    sign    = a[31] ^ b[31];
    ma      = {1'b1, a[22:0]};
    mb      = {1'b1, b[22:0]};
    p       = {24'd0, ma} * {24'd0, mb};

    hi      = p[47];
    m24     = hi ? p[47:24] : p[46:23];
    guard   = hi ? p[23] : p[22];
    sticky  = hi ? (|p[22:0]) : (|p[21:0]);
    rnd     = guard & (sticky | m24[0]);
    mr      = {1'b0, m24} + {24'd0, rnd};
    frac    = mr[24] ? mr[23:1] : mr[22:0];

    // Two's-complement exponent: bit 9 set means the product underflowed.
    exp_n   = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127
            + {9'd0, hi} + {9'd0, mr[24]};

    if (zero_in || exp_n[9] || exp_n == 10'd0) y = FP_ZERO;
    else if (exp_n >= 10'd255)                 y = {sign, 8'hFF, 23'd0};
    else                                       y = {sign, exp_n[7:0], frac};
  end

endmodule

// File: rtl/fft.sv
// 8-point radix-2 DIT FFT on binary32 real samples: combinational butterflies feeding a result bank.
// The result bank loads every clock; a 3-bit select reads one bin combinationally.
module fft
  import fft_pkg::*;
(
  input  logic       rst,
  input  logic [2:0] s,
  input  float32_t   x0,
  input  float32_t   x1,
  input  float32_t   x2,
  input  float32_t   x3,
  input  float32_t   x4,
  input  float32_t   x5,
  input  float32_t   x6,
  input  float32_t   x7,
  output float32_t   real_out,
  output float32_t   img_out,
  input  logic       clk
);

  float32_t xv  [N];
  cplx_t    st0 [N];
  cplx_t    st1 [N];
  cplx_t    st2 [N];
  cplx_t    st3 [N];
  cplx_t    res [N];

  assign xv = '{x0, x1, x2, x3, x4, x5, x6, x7};

  for (genvar i = 0; i < N; i++) begin : g_rev
    assign st0[i] = '{re: xv[bitrev(i)], im: FP_ZERO};
  end

  for (genvar b = 0; b < N/2; b++) begin : g_s1
    fft_bfly #(.TW(0)) u_bf (
      .a(st0[2*b]), .b(st0[2*b+1]), .p(st1[2*b]), .q(st1[2*b+1])
    );
  end

  for (genvar b = 0; b < N/2; b++) begin : g_s2
    localparam int TOP = (b / 2) * 4 + (b % 2);
    fft_bfly #(.TW((b % 2) * 2)) u_bf (
      .a(st1[TOP]), .b(st1[TOP+2]), .p(st2[TOP]), .q(st2[TOP+2])
    );
  end

  for (genvar b = 0; b < N/2; b++) begin : g_s3
    fft_bfly #(.TW(b)) u_bf (
      .a(st2[b]), .b(st2[b+4]), .p(st3[b]), .q(st3[b+4])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) res[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) res[i] <= st3[i];
    end
  end

  assign real_out = res[s].re;
  assign img_out  = res[s].im;

endmodule

// File: tb/tb_fft.sv
// Directed, table-driven bench for the 8-point FFT: per-bin expected values, reset and select timing.
// Bins that are irrational multiples of sqrt(2)/2 are accepted within one ulp of the nearest binary32.
module tb_fft;
  import fft_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  s;
  logic [31:0] x [8];
  logic [31:0] real_out, img_out;

  int n_pass = 0;
  int n_total = 0;

  fft dut (
    .rst(rst), .s(s),
    .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]),
    .x4(x[4]), .x5(x[5]), .x6(x[6]), .x7(x[7]),
    .real_out(real_out), .img_out(img_out), .clk(clk)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0][31:0] xs;
    logic [7:0][31:0] re;
    logic [7:0][31:0] im;
    logic [7:0]       tol;
  } vec_t;

  vec_t vt [4];

  function automatic logic [7:0][31:0] mk8(
    input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] a3,
    input logic [31:0] a4, input logic [31:0] a5, input logic [31:0] a6, input logic [31:0] a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv,
                       input logic tol);
    logic        ok;
    logic [31:0] d;
    n_total++;
    d  = (act > expv) ? act - expv : expv - act;
    ok = tol ? ((act[31] === expv[31]) && (d <= 32'd1)) : (act === expv);
    if (ok) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, expv);
  endtask

  task automatic apply(input logic [7:0][31:0] xs);
    @(negedge clk);
    for (int i = 0; i < 8; i++) x[i] = xs[i];
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Ramp pairs {7,7,11,11,13,13,15,15}
    vt[0].xs  = mk8(32'h40E00000, 32'h40E00000, 32'h41300000, 32'h41300000,
                    32'h41500000, 32'h41500000, 32'h41700000, 32'h41700000);
    vt[0].re  = mk8(32'h42B80000, 32'hC0ED413D, 32'hC0C00000, 32'hC092BEC3,
                    32'h00000000, 32'hC092BEC3, 32'hC0C00000, 32'hC0ED413D);
    vt[0].im  = mk8(32'h00000000, 32'h41312318, 32'h40C00000, 32'h40448C60,
                    32'h00000000, 32'hC0448C60, 32'hC0C00000, 32'hC1312318);
    vt[0].tol = 8'b1010_1010;
    // Impulse
    vt[1].xs  = mk8(32'h3F800000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    vt[1].re  = mk8(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                    32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    vt[1].im  = '0;
    vt[1].tol = 8'b0;
    // DC 2.0
    vt[2].xs  = mk8(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000,
                    32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000);
    vt[2].re  = mk8(32'h41800000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    vt[2].im  = '0;
    vt[2].tol = 8'b0;
    // Alternating +1/-1
    vt[3].xs  = mk8(32'h3F800000, 32'hBF800000, 32'h3F800000, 32'hBF800000,
                    32'h3F800000, 32'hBF800000, 32'h3F800000, 32'hBF800000);
    vt[3].re  = mk8(32'h0, 32'h0, 32'h0, 32'h0, 32'h41000000, 32'h0, 32'h0, 32'h0);
    vt[3].im  = '0;
    vt[3].tol = 8'b0;

    // Reset with nonzero inputs applied: every bin must read zero.
    rst = 1'b1;
    s   = 3'd0;
    for (int i = 0; i < 8; i++) x[i] = vt[0].xs[i];
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      s = 3'(k);
      #1;
      check($sformatf("reset X%0d re", k), real_out, 32'h0, 1'b0);
      check($sformatf("reset X%0d im", k), img_out,  32'h0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      apply(vt[v].xs);
      for (int k = 0; k < 8; k++) begin
        s = 3'(k);
        #1;
        check($sformatf("set%0d X%0d re", v, k), real_out, vt[v].re[k], vt[v].tol[k]);
        check($sformatf("set%0d X%0d im", v, k), img_out,  vt[v].im[k], vt[v].tol[k]);
      end
    end

    // Select-only changes between edges (alternating inputs still held, s was 7).
    @(negedge clk);
    s = 3'd4;
    #1;
    check("sel X4 re", real_out, 32'h41000000, 1'b0);
    s = 3'd2;
    #1;
    check("sel X2 re", real_out, 32'h0, 1'b0);
    s = 3'd4;
    #1;
    check("sel X4 re again", real_out, 32'h41000000, 1'b0);

    // One-edge latency: new inputs are invisible until the next rising edge.
    apply(vt[2].xs);
    s = 3'd0;
    #1;
    check("dc X0 before change", real_out, 32'h41800000, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 8; i++) x[i] = vt[1].xs[i];
    #1;
    check("latency hold X0", real_out, 32'h41800000, 1'b0);
    @(posedge clk);
    #1;
    check("latency load X0", real_out, 32'h3F800000, 1'b0);

    // Mid-stream reset discards held results; first valid one edge after release.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst X0 re", real_out, 32'h0, 1'b0);
    s = 3'd5;
    #1;
    check("midrst X5 re", real_out, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-rst before edge", real_out, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check("post-rst X5 re", real_out, 32'h3F800000, 1'b0);
    check("post-rst X5 im", img_out,  32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
